// File: rtl/stack_arb_pkg.sv
// Shared encodings for the stack arbiter: FSM states and request op codes.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_i, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    localparam int unsigned N = NUM_REQ;

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IDX_W'((32'(last_i) + k) % N);
            if (!any_o && req_i[idx]) begin
                any_o       = 1'b1;
                grant_o     = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack among NUM_REQ requesters; one operation
// in flight at a time, answered with a single-cycle tagged response.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    input  logic [NUM_REQ-1:0]             REQ_POP,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]             REQ_READY,
    output logic                           RSP_VALID,
    output logic [ID_WIDTH-1:0]            RSP_ID,
    output logic [DATA_WIDTH-1:0]          RSP_DATA,
    output logic                           RSP_ERR,
    output logic                           STK_PUSH,
    output logic                           STK_POP,
    output logic [DATA_WIDTH-1:0]          STK_DATA_IN,
    input  logic [DATA_WIDTH-1:0]          STK_DATA_OUT,
    input  logic                           STK_FULL,
    input  logic                           STK_EMPTY
);

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     last_q, last_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    push_q, push_d;
    logic                    pop_q, pop_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]      gnt;
    logic [ID_WIDTH-1:0]     gnt_idx;
    logic                    gnt_any;
    logic                    gnt_op;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic                    gnt_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_WIDTH)
    ) u_rr (
        .req_i       (REQ_VALID),
        .last_i      (last_q),
        .grant_o     (gnt),
        .grant_idx_o (gnt_idx),
        .any_o       (gnt_any)
    );

    always_comb begin
        gnt_op   = REQ_POP[gnt_idx];
        gnt_data = REQ_DATA[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        gnt_err  = ((gnt_op == OP_PUSH) && STK_FULL) || ((gnt_op == OP_POP) && STK_EMPTY);
    end

    // Strobes and responses are decided one cycle ahead so every output leaves a flop.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        din_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_err_d   = 1'b0;
        REQ_READY   = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any && !RST) begin
                    REQ_READY = gnt;
                    id_d      = gnt_idx;
                    last_d    = gnt_idx;
                    if (gnt_err) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = gnt_idx;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        push_d  = (gnt_op == OP_PUSH);
                        pop_d   = (gnt_op == OP_POP);
                        din_d   = (gnt_op == OP_PUSH) ? gnt_data : '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_WIDTH'(NUM_REQ - 1);
            id_q        <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign STK_PUSH    = push_q;
    assign STK_POP     = pop_q;
    assign STK_DATA_IN = din_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ID      = rsp_id_q;
    assign RSP_ERR     = rsp_err_q;
    // The stack's DATA_OUT already reflects the strobe in the response cycle.
    assign RSP_DATA    = (rsp_valid_q && !rsp_err_q) ? STK_DATA_OUT : '0;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural stack, transaction-level LIFO/round-robin model, directed tests.
module tb_stack_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 8;

    logic                    CLK;
    logic                    RST;
    logic [NUM_REQ-1:0]      REQ_VALID;
    logic [NUM_REQ-1:0]      REQ_POP;
    logic [NUM_REQ*DW-1:0]   REQ_DATA;
    logic [NUM_REQ-1:0]      REQ_READY;
    logic                    RSP_VALID;
    logic [0:0]              RSP_ID;
    logic [DW-1:0]           RSP_DATA;
    logic                    RSP_ERR;
    logic                    STK_PUSH;
    logic                    STK_POP;
    logic [DW-1:0]           STK_DATA_IN;
    logic [DW-1:0]           STK_DATA_OUT;
    logic                    STK_FULL;
    logic                    STK_EMPTY;

    int errors = 0;
    int checks = 0;

    stack_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ID_WIDTH   (1),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ_VALID    (REQ_VALID),
        .REQ_POP      (REQ_POP),
        .REQ_DATA     (REQ_DATA),
        .REQ_READY    (REQ_READY),
        .RSP_VALID    (RSP_VALID),
        .RSP_ID       (RSP_ID),
        .RSP_DATA     (RSP_DATA),
        .RSP_ERR      (RSP_ERR),
        .STK_PUSH     (STK_PUSH),
        .STK_POP      (STK_POP),
        .STK_DATA_IN  (STK_DATA_IN),
        .STK_DATA_OUT (STK_DATA_OUT),
        .STK_FULL     (STK_FULL),
        .STK_EMPTY    (STK_EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural stack with a registered DATA_OUT and a run-time depth.
    logic          stk_rst;
    int            stk_depth;
    logic [DW-1:0] smem [0:7];
    int            scount;
    logic [DW-1:0] sdout;

    always @(posedge CLK) begin
        if (stk_rst) begin
            scount <= 0;
            sdout  <= '0;
        end else if (STK_PUSH && scount < stk_depth) begin
            smem[scount] <= STK_DATA_IN;
            scount       <= scount + 1;
            sdout        <= STK_DATA_IN;
        end else if (STK_POP && scount > 0) begin
            scount <= scount - 1;
            sdout  <= smem[scount-1];
        end
    end

    assign STK_DATA_OUT = sdout;
    assign STK_FULL     = (scount == stk_depth);
    assign STK_EMPTY    = (scount == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Transaction-level model: one op in flight, fixed latencies, LIFO contents.
    int            cyc = 0;
    bit            armed = 0;
    int            free_cyc;
    int            mlast;
    logic [DW-1:0] lifo [$];
    bit            st_pend, st_pop;
    int            st_cyc;
    logic [DW-1:0] st_data;
    bit            rs_pend, rs_err;
    int            rs_cyc, rs_id;
    logic [DW-1:0] rs_data;

    always @(negedge CLK) begin : model
        logic [NUM_REQ-1:0] e_ready;
        bit                 e_push, e_pop, e_rv, e_err;
        logic [DW-1:0]      e_din, e_rd;
        int                 e_id, w;
        cyc++;
        if (!armed) begin
            if (RST) begin
                armed    = 1;
                mlast    = NUM_REQ - 1;
                free_cyc = cyc + 1;
                st_pend  = 0;
                rs_pend  = 0;
                lifo.delete();
            end
        end else begin
            e_ready = '0; e_push = 0; e_pop = 0; e_rv = 0; e_err = 0;
            e_din = '0; e_rd = '0; e_id = 0;
            if (st_pend && st_cyc == cyc) begin
                st_pend = 0;
                if (st_pop) begin
                    e_pop = 1;
                    if (lifo.size() > 0) begin
                        rs_data = lifo[$];
                        void'(lifo.pop_back());
                    end
                end else begin
                    e_push = 1;
                    e_din  = st_data;
                    lifo.push_back(st_data);
                end
            end
            if (rs_pend && rs_cyc == cyc) begin
                rs_pend = 0;
                e_rv = 1; e_id = rs_id; e_rd = rs_data; e_err = rs_err;
            end
            if (!RST && cyc >= free_cyc) begin
                w = rr_pick(REQ_VALID, mlast);
                if (w >= 0) begin
                    e_ready[w] = 1'b1;
                    mlast   = w;
                    rs_id   = w;
                    rs_pend = 1;
                    rs_err  = REQ_POP[w] ? (lifo.size() == 0) : (lifo.size() >= stk_depth);
                    if (rs_err) begin
                        rs_data  = '0;
                        rs_cyc   = cyc + 1;
                        free_cyc = cyc + 2;
                    end else begin
                        st_pend  = 1;
                        st_cyc   = cyc + 1;
                        st_pop   = REQ_POP[w];
                        st_data  = REQ_POP[w] ? '0 : REQ_DATA[w*DW +: DW];
                        rs_data  = st_data;
                        rs_cyc   = cyc + 2;
                        free_cyc = cyc + 3;
                    end
                end
            end
            check("m_ready", REQ_READY, e_ready);
            check("m_push", STK_PUSH, e_push);
            check("m_pop", STK_POP, e_pop);
            check("m_rsp_valid", RSP_VALID, e_rv);
            if (e_push || e_pop) check("m_din", STK_DATA_IN, e_din);
            if (e_rv) begin
                check("m_rsp_id", RSP_ID, e_id);
                check("m_rsp_data", RSP_DATA, e_rd);
                check("m_rsp_err", RSP_ERR, e_err);
            end
            if (RST) begin
                mlast    = NUM_REQ - 1;
                free_cyc = cyc + 1;
                st_pend  = 0;
                rs_pend  = 0;
            end
            if (stk_rst) lifo.delete();
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input bit with_stack);
        tick();
        RST = 1'b1; stk_rst = with_stack; REQ_VALID = '0; REQ_POP = '0;
        tick();
        RST = 1'b0; stk_rst = 1'b0;
    endtask

    logic [NUM_REQ-1:0] rdy_r [0:9];
    logic               rv_r [0:9], err_r [0:9], push_r [0:9], pop_r [0:9], id_r [0:9], emp_r [0:9];
    logic [DW-1:0]      rd_r [0:9], so_r [0:9];

    task automatic record(input int k);
        rdy_r[k] = REQ_READY; rv_r[k] = RSP_VALID; err_r[k] = RSP_ERR; rd_r[k] = RSP_DATA;
        push_r[k] = STK_PUSH; pop_r[k] = STK_POP; id_r[k] = RSP_ID;
        so_r[k] = STK_DATA_OUT; emp_r[k] = STK_EMPTY;
    endtask

    initial begin : stim
        int gcyc [$];
        int gid [$];
        int npush, npop;
        RST = 1'b1; stk_rst = 1'b1; stk_depth = 4;
        REQ_VALID = '0; REQ_POP = '0; REQ_DATA = '0;

        // Reset state, then a lone push of 0xA5 from requester 0.
        do_reset(1);
        @(negedge CLK);
        check("rst_ready", REQ_READY, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_push", STK_PUSH, 0);
        check("rst_pop", STK_POP, 0);
        check("rst_din", STK_DATA_IN, 0);
        tick();
        REQ_VALID = 2'b01; REQ_POP = 2'b00; REQ_DATA = {8'h00, 8'hA5};
        @(negedge CLK); check("t1_grant", REQ_READY, 2'b01);
        tick(); REQ_VALID = '0;
        @(negedge CLK); check("t1_strobe", STK_PUSH, 1); check("t1_din", STK_DATA_IN, 8'hA5);
        tick();
        @(negedge CLK);
        check("t1_rv", RSP_VALID, 1); check("t1_id", RSP_ID, 0);
        check("t1_data", RSP_DATA, 8'hA5); check("t1_err", RSP_ERR, 0);
        tick();

        // Both requesters hold a push: grants alternate 0,1,0,1 every 3 cycles.
        stk_depth = 4;
        do_reset(1);
        REQ_VALID = 2'b11; REQ_POP = 2'b00; REQ_DATA = {8'h20, 8'h10};
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (REQ_READY != '0) begin
                gcyc.push_back(k);
                gid.push_back(REQ_READY == 2'b10 ? 1 : 0);
            end
            tick();
        end
        REQ_VALID = '0;
        check("t2_ngrants", gcyc.size(), 4);
        for (int i = 0; i < gcyc.size(); i++) begin
            check("t2_gcyc", gcyc[i], 3 * i);
            check("t2_gid", gid[i], i % 2);
        end
        repeat (3) tick();

        // Depth-2 stack, three pushes from requester 1: the third errors without a strobe.
        stk_depth = 2;
        do_reset(1);
        REQ_VALID = 2'b10; REQ_POP = 2'b00; REQ_DATA = {8'h31, 8'h00};
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK); record(k); tick();
            if (k == 6) REQ_VALID = '0;
        end
        check("t3_grant3", rdy_r[6], 2'b10);
        check("t3_rv", rv_r[7], 1); check("t3_err", err_r[7], 1);
        check("t3_data", rd_r[7], 0); check("t3_id", id_r[7], 1);
        npush = 0;
        for (int k = 6; k < 10; k++) npush += int'(push_r[k]);
        check("t3_no_push", npush, 0);
        check("t3_no_rv8", rv_r[8], 0);

        // Pop on an empty stack right after reset.
        stk_depth = 4;
        do_reset(1);
        REQ_VALID = 2'b01; REQ_POP = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); record(k); tick();
            if (k == 0) REQ_VALID = '0;
        end
        check("t4_grant", rdy_r[0], 2'b01);
        check("t4_rv", rv_r[1], 1); check("t4_err", err_r[1], 1); check("t4_data", rd_r[1], 0);
        npop = 0;
        for (int k = 0; k < 4; k++) npop += int'(pop_r[k]);
        check("t4_no_pop", npop, 0);

        // Push 0x11 from requester 0, then pop it from requester 1.
        REQ_VALID = 2'b01; REQ_POP = 2'b00; REQ_DATA = {8'h00, 8'h11};
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK); record(k); tick();
            if (k == 0) begin REQ_VALID = 2'b10; REQ_POP = 2'b10; end
            if (k == 3) REQ_VALID = '0;
        end
        check("t5_grant_pop", rdy_r[3], 2'b10);
        check("t5_strobe", pop_r[4], 1);
        check("t5_rv", rv_r[5], 1); check("t5_id", id_r[5], 1);
        check("t5_data", rd_r[5], 8'h11); check("t5_data_eq_out", rd_r[5], so_r[5]);
        check("t5_empty", emp_r[5], 1);

        // Reset while the push strobe is out: request abandoned, requester 0 first again.
        do_reset(1);
        REQ_VALID = 2'b01; REQ_POP = 2'b00; REQ_DATA = {8'h77, 8'h42};
        @(negedge CLK); check("t6_grant", REQ_READY, 2'b01);
        tick(); RST = 1'b1; REQ_VALID = '0;
        @(negedge CLK); check("t6_strobe_kept", STK_PUSH, 1);
        tick(); RST = 1'b0;
        @(negedge CLK);
        check("t6_ready0", REQ_READY, 0); check("t6_rv0", RSP_VALID, 0);
        check("t6_id0", RSP_ID, 0); check("t6_data0", RSP_DATA, 0); check("t6_err0", RSP_ERR, 0);
        check("t6_push0", STK_PUSH, 0); check("t6_pop0", STK_POP, 0); check("t6_din0", STK_DATA_IN, 0);
        tick(); REQ_VALID = 2'b11;
        @(negedge CLK); check("t6_regrant", REQ_READY, 2'b01); check("t6_no_rsp", RSP_VALID, 0);
        tick(); REQ_VALID = '0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one stack instance between NUM_REQ independent requesters.
- Each requester issues push or pop through a valid/ready handshake. The arbiter grants one request at a time, round-robin.
- Checks the stack's FULL/EMPTY flags, drives the stack's PUSH/POP strobes, and returns a tagged single-cycle response carrying data or an error.
- Sits between the requesting datapath units and the stack. Nothing drives the stack directly.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ID_WIDTH, 1: width of RSP_ID; must be >= ceil(log2(NUM_REQ)).
- DATA_WIDTH, 8: stack word width; must match the stack instance.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_POP  in  NUM_REQ  per-requester op: 1=pop, 0=push.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  push data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_READY  out  NUM_REQ  one-hot grant; request consumed when VALID&READY.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_ID  out  ID_WIDTH  index of the requester being answered.
- RSP_DATA  out  DATA_WIDTH  pushed word echoed, or popped word; 0 on error.
- RSP_ERR  out  1  1 = push while full or pop while empty; stack not touched.
- STK_PUSH  out  1  to stack PUSH.
- STK_POP  out  1  to stack POP.
- STK_DATA_IN  out  DATA_WIDTH  to stack DATA_IN.
- STK_DATA_OUT  in  DATA_WIDTH  from stack DATA_OUT.
- STK_FULL  in  1  from stack FULL.
- STK_EMPTY  in  1  from stack EMPTY.

Behaviour:
- Reset (RST high at a clock edge):
  - state=IDLE, last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: REQ_READY, RSP_*, STK_PUSH, STK_POP, STK_DATA_IN.
  - Reset mid-operation abandons any latched request with no response. A strobe already issued stays in the stack. No strobe is asserted in the reset cycle.
- FSM, registered outputs, states IDLE, ISSUE, RESP:
  - IDLE:
    - If any REQ_VALID is set, pick the first valid requester in round-robin order starting at last+1 (wrap at NUM_REQ).
    - Set REQ_READY[winner]=1 combinationally in this cycle only.
    - Latch id, op and data, and update last=winner.
    - If (push & STK_FULL) or (pop & STK_EMPTY), set err and go to RESP. Otherwise go to ISSUE.
  - ISSUE:
    - Assert exactly one of STK_PUSH/STK_POP for exactly one cycle, with STK_DATA_IN=latched data (0 for pop). Go to RESP.
  - RESP:
    - RSP_VALID=1, RSP_ID=latched id, RSP_ERR=err.
    - RSP_DATA=STK_DATA_OUT if !err, else 0.
    - Go to IDLE.
    - STK_FULL/STK_EMPTY are already updated in this cycle, so the next IDLE decision sees the new flags.
- Timing:
  - Legal op: grant at cycle N, strobe at N+1, response at N+2, next grant no earlier than N+3.
  - Error op: grant N, response N+1, next grant N+2.
- REQ_READY is 0 outside IDLE. A requester may hold VALID across busy cycles. Dropping VALID before grant is legal and leaves no side effect.
- Never asserts STK_PUSH and STK_POP together. Never strobes the stack when the flag forbids it. The stack's push-over-pop precedence is therefore never exercised.
- REQ_VALID on a requester index >= NUM_REQ cannot occur, because the width is exact.
- No response back-pressure: consumers must accept RSP_VALID whenever it pulses.

Decomposition:
- Package stack_arb_pkg:
  - State encoding localparams: ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2.
  - Op encoding: OP_PUSH=1'b0, OP_POP=1'b1.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational; the pointer register lives in stack_arbiter.

Test Plan:
- Reset, then req0 push 0xA5 alone -> REQ_READY=01 at N; STK_PUSH=1, STK_DATA_IN=0xA5 at N+1; RSP_VALID=1, RSP_ID=0, RSP_DATA=0xA5, RSP_ERR=0 at N+2.
- Both requesters hold valid push continuously -> grants alternate 0,1,0,1 spaced 3 cycles apart.
- Stack with DEPTH=2, three pushes from req1 -> third response has RSP_ERR=1, RSP_DATA=0, and no STK_PUSH is asserted for it; grant-to-response is 1 cycle.
- Pop on an empty stack after reset -> RSP_ERR=1 at N+1; STK_POP never asserted.
- Push 0x11, then pop from req1 -> RSP_DATA equals the stack's DATA_OUT at the RESP cycle; STK_EMPTY=1 after the pop.
- RST asserted during ISSUE -> next cycle all outputs 0, no RSP_VALID for the abandoned request; the next grant goes to requester 0.
